// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_lsu data memory: funct3 and FSM encodings,
// byte-enable generation and load extraction/extension.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [2:0] {IDLE, RD, RD2, WR2, RESP} state_e;

  // Eight lanes: [3:0] land in word w, [7:4] spill into word w+1.
  function automatic logic [7:0] be_of(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] load_ext(input logic [63:0] dword, input logic [1:0] off,
                                           input logic [2:0] funct3);
    logic [31:0] s;
    s = 32'(dword >> {off, 3'b000});
    case (funct3_e'(funct3))
      F3_B:    return {{24{s[7]}}, s[7:0]};
      F3_H:    return {{16{s[15]}}, s[15:0]};
      F3_W:    return s;
      F3_BU:   return {24'b0, s[7:0]};
      F3_HU:   return {16'b0, s[15:0]};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-lane data RAM: four 8-bit lanes sharing one word address, registered read,
// write-first on the written lanes.
module dmem_bank #(
  parameter int    AW        = 7,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [3:0][7:0] mem [DEPTH];

  // NOTE: RAM contents and the read register carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[addr][i]     <= wdata[8*i +: 8];
        rdata[8*i +: 8]  <= wdata[8*i +: 8];
      end else begin
        rdata[8*i +: 8]  <= mem[addr][i];
      end
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit over byte-banked data RAM with valid/ready request and response.
// Define DMEM_MISALIGN_SPLIT_EN to split word-crossing accesses instead of flagging them.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int    ADDR_W    = 9,
  parameter int    DATA_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int WORD_W = ADDR_W - 2;

  if (DATA_W != 32) begin : g_bad_width
    $error("dmem_lsu supports DATA_W == 32 only");
  end

  state_e            state;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              accept, req_cross, req_illegal, req_err;
  logic [1:0]        req_off;
  logic [WORD_W-1:0] req_word;
  logic [7:0]        req_be;
  logic [WORD_W-1:0] bank_addr;
  logic [3:0]        bank_be;
  logic [31:0]       bank_wdata, bank_rdata;

  assign accept    = req_valid & req_ready;
  assign req_off   = req_addr[1:0];
  assign req_word  = req_addr[ADDR_W-1:2];
  assign req_be    = be_of(req_funct3[1:0], req_off);
  assign req_cross = |req_be[7:4];
  assign req_illegal = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                              : ((req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11));

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [WORD_W-1:0] word_q;
  logic              cross_q;
  logic [3:0]        be_hi_q;
  logic [31:0]       wdata_hi_q, lo_q;
  logic [63:0]       wdata_sh;
  assign wdata_sh = {32'b0, req_wdata} << {req_off, 3'b000};
  assign req_err  = req_illegal;
`else
  logic [31:0]       wdata_sh;
  assign wdata_sh = req_wdata << {req_off, 3'b000};
  assign req_err  = req_illegal | req_cross;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    bank_addr  = req_word;
    bank_be    = '0;
    bank_wdata = wdata_sh[31:0];
    case (state)
      IDLE: if (accept && req_we && !req_err) bank_be = req_be[3:0];
`ifdef DMEM_MISALIGN_SPLIT_EN
      RD:   bank_addr = word_q + WORD_W'(1);
      WR2: begin
        bank_addr  = word_q + WORD_W'(1);
        bank_be    = be_hi_q;
        bank_wdata = wdata_hi_q;
      end
`endif
      default: ;
    endcase
  end

  dmem_bank #(.AW(WORD_W), .INIT_FILE(INIT_FILE)) u_bank (
    .clk   (clk),
    .addr  (bank_addr),
    .be    (bank_be),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  // NOTE: sequential state uses <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      off_q     <= '0;
      f3_q      <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
      word_q     <= '0;
      cross_q    <= 1'b0;
      be_hi_q    <= '0;
      wdata_hi_q <= '0;
      lo_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            off_q     <= req_off;
            f3_q      <= req_funct3;
`ifdef DMEM_MISALIGN_SPLIT_EN
            word_q     <= req_word;
            cross_q    <= req_cross;
            be_hi_q    <= req_be[7:4];
            wdata_hi_q <= wdata_sh[63:32];
`endif
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else if (req_we) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
              if (req_cross) state <= WR2;
              else
`endif
              begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
                state     <= RESP;
              end
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
          if (cross_q) begin
            lo_q  <= bank_rdata;
            state <= RD2;
          end else
`endif
          begin
            rsp_rdata <= load_ext({32'b0, bank_rdata}, off_q, f3_q);
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        RD2: begin
          rsp_rdata <= load_ext({bank_rdata, lo_q}, off_q, f3_q);
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        WR2: begin
          rsp_rdata <= '0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: stimulus pushes expected responses, a negedge monitor
// pops and compares data, error flag and latency.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   last_acc = 0;
  int   hs_cycle = 0;
  int   next_id = 0;
  bit   seen = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: compares the head of the scoreboard every cycle the response is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = q[0];
        if (!seen) begin
          check($sformatf("latency[%0d]", e.id), cycle - e.acc + 1, e.lat);
          seen = 1;
        end
        check($sformatf("rdata[%0d]", e.id), rsp_rdata, e.rdata);
        check($sformatf("err[%0d]", e.id), 32'(rsp_err), 32'(e.err));
        if (!rsp_ready) check($sformatf("req_ready_held[%0d]", e.id), 32'(req_ready), 32'd0);
        else begin
          void'(q.pop_front());
          seen = 0;
          hs_cycle = cycle;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat, input bit push);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    last_acc = cycle;
    if (push) begin
      e.rdata = er; e.err = ee; e.lat = lat; e.acc = cycle; e.id = next_id;
      q.push_back(e);
    end
    next_id++;
  endtask

  task automatic st(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d, input int lat);
    issue(1'b1, f3, a, d, 32'h0, 1'b0, lat, 1'b1);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] er, input int lat);
    issue(1'b0, f3, a, 32'h0, er, 1'b0, lat, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Known background for later loads
    st(3'b010, 9'h014, 32'h0000_0000, 1);
    st(3'b010, 9'h030, 32'hAAAA_AAAA, 1);
    st(3'b010, 9'h034, 32'h5555_5555, 1);

    // 1: word store/load
    st(3'b010, 9'h010, 32'hDEAD_BEEF, 1);
    ld(3'b010, 9'h010, 32'hDEAD_BEEF, 2);

    // 2: byte store, signed/unsigned byte loads, word readback
    st(3'b000, 9'h013, 32'h0000_0080, 1);
    ld(3'b000, 9'h013, 32'hFFFF_FF80, 2);
    ld(3'b100, 9'h013, 32'h0000_0080, 2);
    ld(3'b010, 9'h010, 32'h80AD_BEEF, 2);

    // 3: halfword, illegal funct3 load and store
    st(3'b001, 9'h022, 32'h0000_BEEF, 1);
    ld(3'b001, 9'h022, 32'hFFFF_BEEF, 2);
    ld(3'b101, 9'h022, 32'h0000_BEEF, 2);
    ld(3'b001, 9'h012, 32'hFFFF_80AD, 2);
    issue(1'b0, 3'b011, 9'h020, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b110, 9'h020, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b100, 9'h010, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b1);
    ld(3'b010, 9'h010, 32'h80AD_BEEF, 2);

    // 4: word-crossing accesses
`ifdef DMEM_MISALIGN_SPLIT_EN
    ld(3'b010, 9'h011, 32'h0080_ADBE, 3);
    st(3'b010, 9'h1FC, 32'h0, 1);
    st(3'b010, 9'h000, 32'h0, 1);
    st(3'b010, 9'h1FE, 32'h1122_3344, 2);
    ld(3'b010, 9'h1FE, 32'h1122_3344, 3);
    ld(3'b010, 9'h1FC, 32'h3344_0000, 2);
    ld(3'b010, 9'h000, 32'h0000_1122, 2);
    ld(3'b001, 9'h013, 32'h0000_0080, 3);
`else
    issue(1'b0, 3'b010, 9'h011, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b010, 9'h011, 32'h1234_5678, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b001, 9'h013, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    ld(3'b010, 9'h010, 32'h80AD_BEEF, 2);
    ld(3'b010, 9'h014, 32'h0000_0000, 2);
`endif

    // 5: response back-pressure, new request must wait for the handshake
    drain();
    rsp_ready = 1'b0;
    ld(3'b010, 9'h010, 32'h80AD_BEEF, 2);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b101; req_addr = 9'h022; req_wdata = '0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    ld(3'b101, 9'h022, 32'h0000_BEEF, 2);
    check("accept_after_hs", 32'(last_acc - hs_cycle >= 2), 32'd1);
    drain();

    // 6: asynchronous reset between halves of a crossing store
    issue(1'b1, 3'b010, 9'h033, 32'h1122_3344, 32'h0, 1'b0, 0, 1'b0);
    #1 rst = 1'b1;
    #1 check("midrst_req_ready", 32'(req_ready), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_ready", 32'(req_ready), 32'd1);
`ifdef DMEM_MISALIGN_SPLIT_EN
    ld(3'b010, 9'h030, 32'h44AA_AAAA, 2);
`else
    ld(3'b010, 9'h030, 32'hAAAA_AAAA, 2);
`endif
    ld(3'b010, 9'h034, 32'h5555_5555, 2);

    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
